// File: rtl/fp_pe_pkg.sv
// Shared floating-point PE constants: operand width, adder latency, zero word.
package fp_pe_pkg;

  localparam int FP_W      = 32;
  localparam int FPADD_LAT = 10;
  localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

endpackage

// File: rtl/fpadd_reduce_seq_pkg.sv
// Local types and helpers for the FP32 reduction sequencer.
package fpadd_reduce_seq_pkg;

  import fp_pe_pkg::*;

  // Outcome of one enabled cycle's candidate selection.
  typedef enum logic [1:0] {
    ISSUE_NONE  = 2'd0,  // nothing new (spare, if any, just sits)
    ISSUE_SPARE = 2'd1,  // a lone candidate is parked in the spare register
    ISSUE_PAIR  = 2'd2   // two candidates are sent to the adder
  } issue_e;

  // Width of a counter able to hold 0..lat+1.
  function automatic int inflight_w(input int lat);
    return $clog2(lat + 2);
  endfunction

endpackage

// File: rtl/fpadd_reduce_seq_if.sv
// Product stream, adder issue/return and result signals of the reduction sequencer.
interface fpadd_reduce_seq_if #(
  parameter int FP_W = fp_pe_pkg::FP_W
);

  logic            in_valid;
  logic [FP_W-1:0] in_data;
  logic            in_last;
  logic            in_ready;
  logic [FP_W-1:0] add_dataa;
  logic [FP_W-1:0] add_datab;
  logic            add_start;
  logic [FP_W-1:0] add_result;
  logic            add_done;
  logic            out_valid;
  logic [FP_W-1:0] out_data;
  logic            busy;

  // Environment side: supplies products and the adder return path.
  modport master (
    output in_valid, in_data, in_last, add_result, add_done,
    input  in_ready, add_dataa, add_datab, add_start, out_valid, out_data, busy
  );

  // Sequencer side.
  modport slave (
    input  in_valid, in_data, in_last, add_result, add_done,
    output in_ready, add_dataa, add_datab, add_start, out_valid, out_data, busy
  );

endinterface

// File: rtl/fpadd_reduce_seq.sv
// Streaming FP32 reduction sequencer: pairs products and returned partial sums
// onto an external fixed-latency adder until one value remains, then emits it.
module fpadd_reduce_seq #(
  parameter int ADD_LAT = fp_pe_pkg::FPADD_LAT,
  parameter int FP_W    = fp_pe_pkg::FP_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clk_en,
  fpadd_reduce_seq_if.slave        bus
);

  import fpadd_reduce_seq_pkg::*;

  localparam int CNT_W = inflight_w(ADD_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ADD_LAT);

  logic [FP_W-1:0]  spare_q;
  logic             spare_v_q;
  logic [CNT_W-1:0] inflight_q;
  logic             draining_q;
  logic [FP_W-1:0]  dataa_q;
  logic [FP_W-1:0]  datab_q;
  logic             add_start_q;
  logic             out_valid_q;
  logic [FP_W-1:0]  out_data_q;

  logic             in_ready;
  logic             accept;
  logic             complete;
  issue_e           issue_d;
  logic [FP_W-1:0]  first_d;
  logic [FP_W-1:0]  second_d;
  logic             spare_used_d;

  // A returned sum plus a waiting spare already fill the pair, so input backs off.
  assign in_ready = clk_en && !reset && !draining_q && !(spare_v_q && bus.add_done);
  assign accept   = bus.in_valid && in_ready;
  // One value left, nothing in the adder and nothing returning: stream is reduced.
  assign complete = draining_q && (inflight_q == '0) && !bus.add_done && spare_v_q;

  // Candidate select in priority order: adder result, accepted input, spare.
  always_comb begin
    issue_d      = ISSUE_NONE;
    first_d      = bus.add_result;
    second_d     = spare_q;
    spare_used_d = 1'b0;
    if (bus.add_done) begin
      first_d = bus.add_result;
      if (accept) begin
        second_d = bus.in_data;
        issue_d  = ISSUE_PAIR;
      end else if (spare_v_q) begin
        second_d     = spare_q;
        spare_used_d = 1'b1;
        issue_d      = ISSUE_PAIR;
      end else begin
        issue_d = ISSUE_SPARE;
      end
    end else if (accept) begin
      first_d = bus.in_data;
      if (spare_v_q) begin
        second_d     = spare_q;
        spare_used_d = 1'b1;
        issue_d      = ISSUE_PAIR;
      end else begin
        issue_d = ISSUE_SPARE;
      end
    end
  end

  // Pairing, spare, in-flight count, drain flag and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      spare_q     <= fp_pe_pkg::FP_ZERO;
      spare_v_q   <= 1'b0;
      inflight_q  <= '0;
      draining_q  <= 1'b0;
      dataa_q     <= fp_pe_pkg::FP_ZERO;
      datab_q     <= fp_pe_pkg::FP_ZERO;
      add_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= fp_pe_pkg::FP_ZERO;
    end else if (clk_en) begin
      add_start_q <= (issue_d == ISSUE_PAIR);
      out_valid_q <= 1'b0;

      if (issue_d == ISSUE_PAIR) begin
        dataa_q <= first_d;
        datab_q <= second_d;
      end

      if (issue_d == ISSUE_SPARE) begin
        spare_q   <= first_d;
        spare_v_q <= 1'b1;
      end else if (spare_used_d) begin
        spare_v_q <= 1'b0;
      end

      // Issue and return in the same cycle cancel out.
      if ((issue_d == ISSUE_PAIR) && !bus.add_done) begin
        inflight_q <= inflight_q + 1'b1;
      end else if ((issue_d != ISSUE_PAIR) && bus.add_done) begin
        inflight_q <= inflight_q - 1'b1;
      end

      if (accept && bus.in_last) begin
        draining_q <= 1'b1;
      end

      if (complete) begin
        out_valid_q <= 1'b1;
        out_data_q  <= spare_q;
        spare_v_q   <= 1'b0;
        draining_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.add_dataa = dataa_q;
  assign bus.add_datab = datab_q;
  assign bus.add_start = add_start_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = draining_q || spare_v_q || (inflight_q != '0);

  a_inflight_max: assert property (@(posedge clk) disable iff (reset)
    inflight_q <= CNT_MAX);

  a_done_protocol: assert property (@(posedge clk) disable iff (reset)
    (clk_en && bus.add_done) |-> (inflight_q != '0));

endmodule

// File: tb/tb_fpadd_reduce_seq.sv
// Directed bench for fpadd_reduce_seq with a delay-line FP32 adder model.
module tb_fpadd_reduce_seq;

  localparam int ADD_LAT = fp_pe_pkg::FPADD_LAT;
  localparam int FP_W    = fp_pe_pkg::FP_W;

  localparam logic [31:0] F1_0  = 32'h3F80_0000;
  localparam logic [31:0] F2_0  = 32'h4000_0000;
  localparam logic [31:0] F2_5  = 32'h4020_0000;
  localparam logic [31:0] F3_0  = 32'h4040_0000;
  localparam logic [31:0] F4_0  = 32'h4080_0000;
  localparam logic [31:0] F5_0  = 32'h40A0_0000;
  localparam logic [31:0] F8_0  = 32'h4100_0000;
  localparam logic [31:0] F10_0 = 32'h4120_0000;
  localparam logic [31:0] F16_0 = 32'h4180_0000;

  logic clk;
  logic reset;
  logic clk_en;

  fpadd_reduce_seq_if #(.FP_W(FP_W)) bus ();

  fpadd_reduce_seq #(.ADD_LAT(ADD_LAT), .FP_W(FP_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FP32 <-> real for positive/negative normals and zero (exact for these sums).
  function automatic real fp2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2fp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52];
    return {d[63], 8'(e - 11'd896), d[51:29]};
  endfunction

  // Adder model: ADD_LAT-stage delay line frozen by clk_en, cleared by reset.
  logic [FP_W-1:0] pipe_d [ADD_LAT];
  logic            pipe_v [ADD_LAT];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ADD_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else if (clk_en) begin
      pipe_v[0] <= bus.add_start;
      pipe_d[0] <= r2fp(fp2r(bus.add_dataa) + fp2r(bus.add_datab));
      for (int i = 1; i < ADD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign bus.add_done   = pipe_v[ADD_LAT-1];
  assign bus.add_result = pipe_d[ADD_LAT-1];

  // Issue/return bookkeeping seen from outside the sequencer.
  int tb_inflight;
  int max_inflight;
  int starts;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tb_inflight <= 0;
    end else if (clk_en) begin
      tb_inflight <= tb_inflight + int'(bus.add_start) - int'(bus.add_done);
      if (tb_inflight + int'(bus.add_start) - int'(bus.add_done) > max_inflight)
        max_inflight <= tb_inflight + int'(bus.add_start) - int'(bus.add_done);
      if (bus.add_start) starts <= starts + 1;
    end
  end

  initial begin
    max_inflight = 0;
    starts       = 0;
  end

  int errors;
  int checks;
  int cyc_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic wait_out(input string tag, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      if (bus.out_valid) begin
        at = cyc_n;
        break;
      end
      cyc();
    end
    if (at < 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic feed(input logic [31:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    cyc();
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int at;
    int acc;
    int drops;
    int viol;
    int s0;
    int pulses;
    int dones;

    errors = 0;
    checks = 0;
    cyc_n  = 0;
    reset  = 1'b1;
    clk_en = 1'b1;
    idle_inputs();
    bus.in_valid = 1'b1;
    bus.in_data  = F1_0;
    repeat (3) cyc();

    // Reset state.
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_add_start", 32'(bus.add_start), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data",  bus.out_data,       32'd0);
    chk("rst_add_dataa", bus.add_dataa,      32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    idle_inputs();
    reset = 1'b0;
    repeat (2) cyc();

    // 1+2+3+4 back-to-back.
    t0 = cyc_n;
    feed(F1_0, 1'b0);
    feed(F2_0, 1'b0);
    feed(F3_0, 1'b0);
    feed(F4_0, 1'b1);
    idle_inputs();
    chk("t1_busy_mid", 32'(bus.busy), 32'd1);
    wait_out("t1", 100, at);
    chk("t1_latency", 32'(at - t0), 32'd27);
    chk("t1_sum", bus.out_data, F10_0);
    chk("t1_busy_fall", 32'(bus.busy), 32'd0);
    cyc();
    chk("t1_single_pulse", 32'(bus.out_valid), 32'd0);
    repeat (2) cyc();

    // Single product: out_valid two cycles later, no adder issue.
    s0 = starts;
    feed(F2_5, 1'b1);
    idle_inputs();
    chk("t2_busy", 32'(bus.busy), 32'd1);
    chk("t2_no_early_out", 32'(bus.out_valid), 32'd0);
    cyc();
    chk("t2_out_valid", 32'(bus.out_valid), 32'd1);
    chk("t2_sum", bus.out_data, F2_5);
    cyc();
    chk("t2_pulse_end", 32'(bus.out_valid), 32'd0);
    chk("t2_no_issue", 32'(starts - s0), 32'd0);
    repeat (2) cyc();

    // 16 ones with in_valid held; input backs off only when a result returns.
    acc   = 0;
    drops = 0;
    viol  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = F1_0;
    for (int k = 0; k < 300 && acc < 16; k++) begin
      bus.in_last = (acc == 15);
      #0;
      if (!bus.in_ready) begin
        drops++;
        if (!bus.add_done) viol++;
      end else begin
        acc++;
      end
      cyc();
    end
    idle_inputs();
    chk("t3_accepted", 32'(acc), 32'd16);
    chk("t3_drop_without_done", 32'(viol), 32'd0);
    chk("t3_some_drops", 32'(drops > 0), 32'd1);
    wait_out("t3", 200, at);
    chk("t3_sum", bus.out_data, F16_0);
    chk("t3_inflight_bound", 32'(max_inflight <= ADD_LAT), 32'd1);
    chk("t3_inflight_zero", 32'(tb_inflight), 32'd0);
    repeat (2) cyc();

    // 8 ones with a 5-cycle clk_en stall after the fourth product.
    t0 = cyc_n;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.in_valid = 1'b1;
        bus.in_data  = F1_0;
        clk_en = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          chk("t4_stall_in_ready", 32'(bus.in_ready), 32'd0);
          chk("t4_stall_add_start", 32'(bus.add_start), 32'd1);
          chk("t4_stall_busy", 32'(bus.busy), 32'd1);
          cyc();
        end
        clk_en = 1'b1;
      end
      feed(F1_0, i == 7);
    end
    idle_inputs();
    wait_out("t4", 200, at);
    chk("t4_latency", 32'(at - t0), 32'd47);
    chk("t4_sum", bus.out_data, F8_0);
    repeat (2) cyc();

    // Reset with three sums in flight, then a fresh 5+5 stream.
    for (int i = 0; i < 6; i++) feed(F1_0, 1'b0);
    idle_inputs();
    cyc();
    chk("t5_inflight_before", 32'(tb_inflight), 32'd3);
    reset = 1'b1;
    #1;
    chk("t5_rst_add_start", 32'(bus.add_start), 32'd0);
    chk("t5_rst_add_dataa", bus.add_dataa,      32'd0);
    chk("t5_rst_out_data",  bus.out_data,       32'd0);
    chk("t5_rst_busy",      32'(bus.busy),      32'd0);
    chk("t5_rst_in_ready",  32'(bus.in_ready),  32'd0);
    cyc();
    reset = 1'b0;
    pulses = 0;
    dones  = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.out_valid) pulses++;
      if (bus.add_done) dones++;
      cyc();
    end
    chk("t5_no_out_after_rst", 32'(pulses), 32'd0);
    chk("t5_no_stale_done", 32'(dones), 32'd0);
    t0 = cyc_n;
    feed(F5_0, 1'b0);
    feed(F5_0, 1'b1);
    idle_inputs();
    wait_out("t5", 100, at);
    chk("t5_latency", 32'(at - t0), 32'd14);
    chk("t5_sum", bus.out_data, F10_0);
    repeat (2) cyc();

    // Two consecutive streams, second starting right after the first result.
    t0 = cyc_n;
    feed(F1_0, 1'b0);
    feed(F1_0, 1'b1);
    idle_inputs();
    wait_out("t6a", 100, at);
    chk("t6a_latency", 32'(at - t0), 32'd14);
    chk("t6a_sum", bus.out_data, F2_0);
    cyc();
    t0 = cyc_n;
    feed(F3_0, 1'b1);
    idle_inputs();
    chk("t6_hold", bus.out_data, F2_0);
    wait_out("t6b", 20, at);
    chk("t6b_latency", 32'(at - t0), 32'd2);
    chk("t6b_sum", bus.out_data, F3_0);
    repeat (3) cyc();
    chk("t6_idle_busy", 32'(bus.busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fpadd_reduce_seq.md
# fpadd_reduce_seq

Streaming FP32 reduction sequencer that sits between the PE multiplier output and the shared 10-cycle floating-point adder. It accepts a stream of FP32 products and issues operand pairs to the external adder, at most one pair per cycle. Returned partial sums are recirculated until the stream has collapsed to a single value, which is emitted as the dot-product result. The adder and its valid pipeline stay outside this block; this block drives their start/operand inputs and consumes their result/done outputs.

## Interface
- `ADD_LAT`, 10, adder latency in cycles (start to done); sizes the in-flight counter only
- `FP_W`, 32, operand width
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `clk_en`  in  1  global enable, shared with the adder; low freezes all state
- `in_valid`  in  1  product valid
- `in_data`  in  FP_W  FP32 product
- `in_last`  in  1  marks final product of a stream
- `in_ready`  out  1  product accepted when `in_valid && in_ready`
- `add_dataa`, `add_datab`  out  FP_W  registered adder operands
- `add_start`  out  1  registered issue strobe to the adder's valid pipeline
- `add_result`  in  FP_W  adder sum
- `add_done`  in  1  `add_result` valid this cycle
- `out_valid`  out  1  one-cycle pulse, final sum valid
- `out_data`  out  FP_W  final sum; holds until the next result
- `busy`  out  1  stream accepted but not yet emitted

## Operation
- State:
  - `spare` register plus `spare_v`
  - `inflight` counter, width `$clog2(ADD_LAT+2)`
  - `draining` flag, set when `in_last` is accepted
- Per enabled cycle, candidate values are, in priority order: R = `add_result` if `add_done`, I = `in_data` if accepted, S = `spare` if `spare_v`.
- Two candidates present:
  - Issue the pair: `add_dataa` gets the first in priority order, `add_datab` the second.
  - `add_start<=1`, `inflight+1`.
  - Consumed spare is cleared.
- One candidate present: it goes to `spare`, or stays there if it already is the spare.
- Three candidates are impossible by construction: `in_ready = clk_en && !draining && !(spare_v && add_done)`. This is combinational from `add_done`, which is legal because `add_done` is registered in the valid pipeline.
- `add_done` decrements `inflight`. When the same cycle also issues, the net change is zero.
- Completion condition: `draining && inflight==0 && !add_done && spare_v`. On that cycle the next edge sets `out_valid<=1` and `out_data<=spare`, and clears `spare_v` and `draining`.
- `busy` = `draining || spare_v || inflight!=0`.
- Summation order is fully determined by the rules above. Bit-exact results are defined only for that order.

## Timing
- Reset values: all outputs 0, `spare_v`=0, `inflight`=0, `draining`=0. `in_ready` is 0 while `reset` is high.
- `add_start` is asserted the cycle after the pairing decision. `add_done` is expected `ADD_LAT` cycles later.
- The final sum lands in `spare` at the end of its `add_done` cycle. `out_valid` follows 2 cycles after that `add_done`.
- Single-product stream accepted in cycle t: `out_valid` in t+2, with no adder issue.
- Two back-to-back products (cycles 0, 1): `add_start` in cycle 2, `add_done` in cycle 12, `out_valid` in cycle 14.
- `clk_en` low: every register holds, `in_ready`=0, and `add_start`/`out_valid` hold their values. The adder is frozen by the same `clk_en`, so no strobe is lost.
- A new stream may start the cycle after `out_valid`.
- Reset mid-stream clears everything. Partial sums are discarded, and the adder is reset by the same `reset`, so no stale `add_done` returns.
- `inflight` never exceeds `ADD_LAT` (at most one issue per cycle); an assertion checks this.
- An `add_done` arriving with `inflight==0` is a protocol error, covered by an assertion.

## Structure
- Shared package `fp_pe_pkg`:
  - `FP_W`=32
  - `FPADD_LAT`=10, the single source for the adder latency and this block's `ADD_LAT`
  - `FP_ZERO`=32'h0000_0000
- No sub-module. Pairing mux, spare register, counter and completion logic sit in one always block plus a small combinational select.
- The bench instantiates the real adder wrapper, or a delay-line adder model of `ADD_LAT` cycles.

## Test plan
- Stream 1.0, 2.0, 3.0, 4.0 (0x3F800000, 0x40000000, 0x40400000, 0x40800000), back-to-back, last on 4.0 -> a single `out_valid` with `out_data`=0x41200000 (10.0), and `busy` falls with it.
- Single product 2.5 (0x40200000) with `in_last` in cycle t -> `out_valid` at t+2, `out_data`=0x40200000, `add_start` never asserted.
- 16 products of 1.0 with `in_valid` held high -> `in_ready` drops exactly on cycles with `spare_v && add_done`, `out_data`=0x41800000 (16.0), and `inflight` stays ≤10.
- `clk_en` low for 5 cycles in mid-stream (1.0 ×8) -> all state frozen, `in_ready`=0, result 0x41000000, latency extended by exactly 5.
- `reset` pulse while 3 sums are in flight -> all outputs 0 next cycle, no `out_valid`. A following stream of 5.0, 5.0 yields 0x41200000.
- Two consecutive streams (1.0, 1.0 then 3.0) -> `out_data` 0x40000000 then 0x40400000, with no cross-stream mixing.
